// File: rtl/timer_pkg.sv
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and constants for the timer controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  // Width of the counter and terminal-count value when not overridden
  localparam int unsigned DEFAULT_WIDTH = 4;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage : timer_pkg

`default_nettype wire

// File: rtl/timer_cnt.sv
// ============================================================================
// Module      : timer_cnt
// Description : WIDTH-bit up-counter with synchronous clear and enable.
//               Clear takes precedence over enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_cnt #(
  parameter int unsigned WIDTH = timer_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // Counter register: clear wins, otherwise increment when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule : timer_cnt

`default_nettype wire

// File: rtl/timer_ctrl.sv
// ============================================================================
// Module      : timer_ctrl
// Description : Run/pause/abort controller around an up-counter with a
//               shadowed terminal count and one-shot / periodic modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  state_e           state_q;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;
  logic             tick_q;
  logic             busy_q;
  logic             done_q;

  logic             cnt_clr;
  logic             cnt_en;
  logic             at_limit;

  // The counter output is the only copy of the count; the FSM compares it
  assign at_limit = (count == limit_q);

  // Counter control: abort > pause > terminal count > increment
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        cnt_clr = abort | start;
      end
      ST_RUN: begin
        if (abort) begin
          cnt_clr = 1'b1;
        end else if (pause) begin
          cnt_clr = 1'b0;
        end else if (at_limit) begin
          // periodic reloads to zero; one-shot holds the limit value
          cnt_clr = periodic_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_PAUSED: begin
        cnt_clr = abort;
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  // State machine, shadow configuration and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      limit_q    <= '1;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // config is only writable while no run is in progress
          if (cfg_load) begin
            limit_q    <= cfg_limit;
            periodic_q <= cfg_periodic;
          end
          if (abort) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end else if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (pause) begin
            state_q <= ST_PAUSED;
          end else if (at_limit) begin
            tick_q <= 1'b1;
            if (!periodic_q) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!pause) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  timer_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (count)
  );

  assign tick = tick_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : timer_ctrl

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// ============================================================================
// Module      : tb_timer_ctrl
// Description : Self-checking bench for timer_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_ctrl;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             cfg_load;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_periodic;
  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tick;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: is a run in progress, is it held, has it finished
  int m_cnt;
  int m_lim;
  bit m_per;
  bit m_active;
  bit m_paused;
  bit m_done;
  bit m_tick;

  timer_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_load     (cfg_load),
    .cfg_limit    (cfg_limit),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .pause        (pause),
    .abort        (abort),
    .count        (count),
    .busy         (busy),
    .tick         (tick),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_lim = (1 << WIDTH) - 1; m_per = 0;
    m_active = 0; m_paused = 0; m_done = 0; m_tick = 0;
  endtask

  // one rising edge of the specified behaviour
  task automatic model_step();
    m_tick = 0;
    if (!m_active) begin
      if (cfg_load) begin
        m_lim = int'(cfg_limit);
        m_per = cfg_periodic;
      end
      if (abort) begin
        m_done = 0; m_cnt = 0;
      end else if (start) begin
        m_active = 1; m_paused = 0; m_done = 0; m_cnt = 0;
      end
    end else if (abort) begin
      m_active = 0; m_paused = 0; m_cnt = 0;
    end else if (pause) begin
      m_paused = 1;
    end else if (m_paused) begin
      m_paused = 0;
    end else if (m_cnt == m_lim) begin
      m_tick = 1;
      if (m_per) m_cnt = 0;
      else begin
        m_active = 0; m_done = 1;
      end
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_step();
    #1;
    check("count", 32'(count), 32'(m_cnt));
    check("busy",  32'(busy),  32'(m_active));
    check("done",  32'(done),  32'(m_done));
    check("tick",  32'(tick),  32'(m_tick));
  endtask

  task automatic set_in(input bit ld, input int lim, input bit per,
                        input bit st, input bit pa, input bit ab);
    cfg_load     = ld;
    cfg_limit    = WIDTH'(lim);
    cfg_periodic = per;
    start        = st;
    pause        = pa;
    abort        = ab;
  endtask

  task automatic run_until_count(input int v, input int max_cycles);
    int k = 0;
    while (int'(count) != v && k < max_cycles) begin
      clk_cycle();
      k++;
    end
    check("reach_count", 32'(count), 32'(v));
  endtask

  initial begin
    int ticks;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_busy",  32'(busy),  0);
    check("rst_done",  32'(done),  0);
    check("rst_tick",  32'(tick),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // idle after reset release
    repeat (20) clk_cycle();

    // one-shot, limit 5
    set_in(1, 5, 0, 1, 0, 0);
    clk_cycle();
    check("os_start_cnt", 32'(count), 0);
    set_in(0, 0, 0, 0, 0, 0);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      clk_cycle();
      if (tick) ticks++;
    end
    check("os_ticks", 32'(ticks), 1);
    check("os_done",  32'(done),  1);
    check("os_hold",  32'(count), 5);

    // periodic, limit 3, started from DONE
    set_in(1, 3, 1, 1, 0, 0);
    clk_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      clk_cycle();
      if (tick) ticks++;
    end
    check("per3_ticks", 32'(ticks), 3);
    set_in(0, 0, 0, 0, 0, 1);
    clk_cycle();

    // periodic, limit 15, pause at 7
    set_in(1, 15, 1, 1, 0, 0);
    clk_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    run_until_count(7, 20);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clk_cycle();
      check("pause_hold", 32'(count), 7);
      check("pause_tick", 32'(tick), 0);
    end
    pause = 1'b0;
    clk_cycle();
    clk_cycle();
    check("resume_cnt", 32'(count), 8);
    run_until_count(15, 20);
    clk_cycle();
    check("wrap_cnt",  32'(count), 0);
    check("wrap_tick", 32'(tick),  1);

    // abort and pause together at 9
    run_until_count(9, 20);
    set_in(0, 0, 0, 0, 1, 1);
    clk_cycle();
    check("abort_cnt",  32'(count), 0);
    check("abort_busy", 32'(busy),  0);

    // cfg_load during run is ignored
    set_in(1, 4, 0, 1, 0, 0);
    clk_cycle();
    set_in(1, 10, 1, 0, 0, 0);
    clk_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    repeat (8) clk_cycle();
    check("ign_done", 32'(done),  1);
    check("ign_cnt",  32'(count), 4);

    // asynchronous reset mid-run
    set_in(1, 15, 1, 1, 0, 0);
    clk_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    run_until_count(6, 20);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_count", 32'(count), 0);
    check("arst_busy",  32'(busy),  0);
    check("arst_done",  32'(done),  0);
    check("arst_tick",  32'(tick),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // limit 0 one-shot finishes one cycle after start
    set_in(1, 0, 0, 1, 0, 0);
    clk_cycle();
    check("z_busy", 32'(busy), 1);
    set_in(0, 0, 0, 0, 0, 0);
    clk_cycle();
    check("z_done", 32'(done), 1);
    check("z_tick", 32'(tick), 1);

    // limit 0 periodic ticks every cycle
    set_in(1, 0, 1, 1, 0, 0);
    clk_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    ticks = 0;
    for (int i = 0; i < 5; i++) begin
      clk_cycle();
      if (tick) ticks++;
    end
    check("z_per_ticks", 32'(ticks), 5);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 5) == 0),
             int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 29) == 0));
      clk_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule : tb_timer_ctrl

`default_nettype wire

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, width of the controlled up-counter and limit.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cfg_load  input  1  capture cfg_limit and cfg_periodic into shadow registers.
REQ-005 cfg_limit  input  WIDTH  terminal count value.
REQ-006 cfg_periodic  input  1  1 = auto-reload at terminal count, 0 = one-shot.
REQ-007 start  input  1  begin counting from 0.
REQ-008 pause  input  1  level; hold count while high in RUN.
REQ-009 abort  input  1  return to IDLE, clear count.
REQ-010 count  output  WIDTH  current counter value.
REQ-011 busy  output  1  high in RUN or PAUSED.
REQ-012 tick  output  1  registered one-cycle pulse at each terminal count.
REQ-013 done  output  1  high while in DONE.

Function
REQ-014 FSM states: IDLE, RUN, PAUSED, DONE; every output registered or decoded from registered state.
REQ-015 cfg_load honoured only in IDLE or DONE; ignored in RUN/PAUSED (shadow values unchanged).
REQ-016 cfg_load and start in the same IDLE/DONE cycle: new config captured and used by that run.
REQ-017 IDLE/DONE + start -> RUN; count = 0 on that edge.
REQ-018 RUN, count != limit, no pause/abort -> count + 1 per cycle.
REQ-019 RUN, count == limit, periodic -> count = 0, tick = 1 next cycle, stay RUN.
REQ-020 RUN, count == limit, one-shot -> DONE, tick = 1 next cycle, count holds limit.
REQ-021 limit = 0: periodic -> tick every cycle, count stays 0; one-shot -> DONE one cycle after start.
REQ-022 limit = 2^WIDTH-1: count reaches all-ones then returns to 0 (periodic); no intermediate overflow.
REQ-023 RUN + pause -> PAUSED, count frozen, no tick; PAUSED + !pause -> RUN, resume from held count.
REQ-024 Priority per cycle: abort > pause > terminal-count > increment; start ignored in RUN/PAUSED.
REQ-025 abort in any state -> IDLE, count = 0, tick = 0 next cycle; shadow config retained.
REQ-026 Pause sampled on the terminal cycle suppresses that terminal event until resumed.
REQ-027 DONE persists until start or abort.

Reset
REQ-028 rst_n low: state = IDLE, count = 0, tick = 0, busy = 0, done = 0, shadow limit = all-ones, shadow periodic = 0, independent of clk.
REQ-029 Reset mid-run discards progress; first start after release counts from 0.

Structure
REQ-030 Shared package timer_pkg: state enum type, default WIDTH constant.
REQ-031 One sub-module timer_cnt: WIDTH-bit up-counter with synchronous clear and enable, async active-low reset; FSM drives clear/enable only.

Verification (WIDTH = 4)
REQ-032 Reset release, no stimulus -> count = 0, busy = 0, done = 0, tick = 0 for 20 cycles.
REQ-033 cfg_load limit = 5 one-shot, start -> count 0..5, tick one cycle, done = 1, count holds 5.
REQ-034 limit = 3 periodic, run 12 cycles -> count 0,1,2,3,0,...; tick every 4th cycle, exactly 3 ticks.
REQ-035 limit = 15 periodic -> count wraps 15 -> 0 with tick; pause at count 7 for 4 cycles -> count stays 7, no tick, then resumes at 8.
REQ-036 abort and pause together at count 9 -> IDLE, count = 0; cfg_load during RUN -> ignored, run finishes at old limit.
REQ-037 rst_n low mid-run at count 6, asynchronous to clk -> outputs clear immediately; limit = 0 one-shot start afterwards -> done after one cycle.
